// File: rtl/tdm_pkg.sv
// Shared TDM definitions for the 1-to-8 demultiplexer and future 8-to-1 transmitter.
// Macro TDM_DEMUX_PARITY_EN adds a ninth (even-parity) slot to every frame.
package tdm_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RECV = 1'b1
  } tdm_state_t;

  localparam int TDM_SLOTS = 8;
  localparam int SLOT_W    = $clog2(TDM_SLOTS);

`ifdef TDM_DEMUX_PARITY_EN
  localparam int FRAME_SLOTS = TDM_SLOTS + 1;
`else
  localparam int FRAME_SLOTS = TDM_SLOTS;
`endif

  localparam int CNT_W = $clog2(FRAME_SLOTS);

endpackage

// File: rtl/tdm_slot_counter.sv
// Wrapping slot counter: clear, enable and terminal-count flag.
// clr and en together restart the count at 1 (slot 0 consumed this cycle).
module tdm_slot_counter #(
  parameter int N = 8,
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] cnt,
  output logic         tc
);

  logic [W-1:0] base;

  // Starting point for this cycle's increment: zero when clearing
  always_comb begin
    base = clr ? '0 : cnt;
  end

  // Counter register; wraps from N-1 back to 0
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= (base == W'(N - 1)) ? '0 : base + 1'b1;
    end else if (clr) begin
      cnt <= '0;
    end
  end

  assign tc = (cnt == W'(N - 1));

endmodule

// File: rtl/tdm_demux_1to8.sv
// Serial TDM to 8-bit parallel frame demultiplexer with valid/ready output.
// Macro TDM_DEMUX_PARITY_EN: 9-slot frames, slot 8 carries even parity over slots 0-7.
module tdm_demux_1to8
  import tdm_pkg::*;
#(
  parameter bit STRICT_SYNC = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 sin,
  input  logic                 sin_valid,
  input  logic                 frame_sync,
  output logic [TDM_SLOTS-1:0] dout,
  output logic                 dout_valid,
  input  logic                 dout_ready,
  output logic [SLOT_W-1:0]    sel,
  output logic                 sync_err,
  output logic                 overrun,
  output logic                 parity_err
);

  tdm_state_t             state, state_nxt;
  logic [CNT_W-1:0]       cnt;
  logic                   cnt_tc;
  logic                   cnt_clr, cnt_en;
  logic                   load0, store, frame_done, sync_hit;
  logic                   in_data;
  logic [TDM_SLOTS-1:0]   shift_p0;
  logic [TDM_SLOTS-1:0]   frame;

  tdm_slot_counter #(
    .N(FRAME_SLOTS),
    .W(CNT_W)
  ) u_slot_counter (
    .clk(clk),
    .rst(rst),
    .clr(cnt_clr),
    .en (cnt_en),
    .cnt(cnt),
    .tc (cnt_tc)
  );

`ifdef TDM_DEMUX_PARITY_EN
  // Parity slot is the ninth count value; sel reads 0 while it is expected
  assign in_data = ~cnt[SLOT_W];
  assign sel     = in_data ? cnt[SLOT_W-1:0] : '0;
  assign frame   = shift_p0;
`else
  assign in_data = 1'b1;
  assign sel     = cnt;
  assign frame   = {sin, shift_p0[TDM_SLOTS-2:0]};
`endif

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and slot-control decode
  always_comb begin
    state_nxt  = state;
    cnt_clr    = 1'b0;
    cnt_en     = 1'b0;
    load0      = 1'b0;
    store      = 1'b0;
    frame_done = 1'b0;
    sync_hit   = 1'b0;
    case (state)
      IDLE: begin
        if (sin_valid && frame_sync) begin
          load0     = 1'b1;
          cnt_clr   = 1'b1;
          cnt_en    = 1'b1;
          state_nxt = RECV;
        end
      end
      RECV: begin
        if (sin_valid) begin
          if (frame_sync) begin
            // Sync at a frame boundary is legal; anywhere else drops the partial frame
            load0    = 1'b1;
            cnt_clr  = 1'b1;
            cnt_en   = 1'b1;
            sync_hit = (cnt != '0);
          end else begin
            store  = 1'b1;
            cnt_en = 1'b1;
            if (cnt_tc) begin
              frame_done = 1'b1;
              if (STRICT_SYNC) begin
                state_nxt = IDLE;
              end
            end
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Slot shift register: slot 0 restarts it, data slots write bit sel
  always_ff @(posedge clk) begin
    if (rst) begin
      shift_p0 <= '0;
    end else if (load0) begin
      shift_p0 <= {{(TDM_SLOTS-1){1'b0}}, sin};
    end else if (store && in_data) begin
      shift_p0[sel] <= sin;
    end
  end

  // Output frame register, handshake and sticky error flags
  always_ff @(posedge clk) begin
    if (rst) begin
      dout       <= '0;
      dout_valid <= 1'b0;
      overrun    <= 1'b0;
      sync_err   <= 1'b0;
    end else begin
      if (sync_hit) begin
        sync_err <= 1'b1;
      end
      if (frame_done) begin
        dout       <= frame;
        dout_valid <= 1'b1;
        if (dout_valid && !dout_ready) begin
          overrun <= 1'b1;
        end
      end else if (dout_valid && dout_ready) begin
        dout_valid <= 1'b0;
      end
    end
  end

`ifdef TDM_DEMUX_PARITY_EN
  // Parity result captured with the frame it belongs to
  always_ff @(posedge clk) begin
    if (rst) begin
      parity_err <= 1'b0;
    end else if (frame_done) begin
      parity_err <= ^{shift_p0, sin};
    end
  end
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: doc/tdm_demux_1to8.md
TDM_DEMUX_1TO8 -- requirements
Module: tdm_demux_1to8

Interface
REQ-001 The block SHALL have parameter STRICT_SYNC, default 1; 1 = return to IDLE after each frame and wait for a new sync, 0 = continue directly into the next frame at slot 0.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port sin, input, 1 bit: serial TDM data, one channel bit per slot.
REQ-005 The block SHALL have port sin_valid, input, 1 bit: sin carries a slot bit this cycle.
REQ-006 The block SHALL have port frame_sync, input, 1 bit: qualified by sin_valid; marks the current bit as slot 0.
REQ-007 The block SHALL have port dout, output, 8 bits: the assembled frame; bit k = slot k.
REQ-008 The block SHALL have port dout_valid, output, 1 bit: dout holds an untaken frame.
REQ-009 The block SHALL have port dout_ready, input, 1 bit: the consumer accepts dout when dout_valid && dout_ready.
REQ-010 The block SHALL have port sel, output, 3 bits: index of the slot expected next.
REQ-011 The block SHALL have port sync_err, output, 1 bit: sticky; set when a sync arrives mid-frame.
REQ-012 The block SHALL have port overrun, output, 1 bit: sticky; set when a frame completes while dout_valid is still set and not taken.
REQ-013 The block SHALL have port parity_err, output, 1 bit: parity failure flag (see Configuration).

Function
REQ-014 The FSM SHALL have states IDLE and RECV.
REQ-015 In IDLE, the block SHALL ignore the bit unless sin_valid && frame_sync; on that condition it SHALL store sin into slot 0, set sel=1 and go to RECV.
REQ-016 In RECV, on each sin_valid without frame_sync, the block SHALL store sin into shift slot sel and increment sel.
REQ-017 When the last data slot is stored, the shift register SHALL be copied to dout, and dout_valid SHALL be set at the next edge (1-cycle latency after the last bit).
REQ-018 Frame end SHALL transition to IDLE if STRICT_SYNC=1, or stay in RECV with sel=0 if STRICT_SYNC=0.
REQ-019 A frame_sync in RECV with sel!=0 SHALL set sync_err, discard the partial frame, store the bit as slot 0 and set sel=1.
REQ-020 A frame_sync in RECV with sel==0 SHALL be legal.
REQ-021 Cycles with sin_valid=0 SHALL hold all state (stall), with no timeout.
REQ-022 A handshake (dout_valid && dout_ready) SHALL clear dout_valid unless a new frame completes in the same cycle, in which case dout SHALL load the new frame and dout_valid SHALL remain 1 with no overrun.
REQ-023 A frame completing while dout_valid=1 and dout_ready=0 SHALL overwrite dout with the new frame and set overrun.
REQ-024 dout SHALL remain stable while dout_valid=1 and no new frame completes.
REQ-025 sync_err and overrun SHALL clear only on rst.

Reset
REQ-026 rst SHALL force state IDLE, sel=0, shift register=0, dout=8'h00, dout_valid=0, sync_err=0, overrun=0 and parity_err=0.
REQ-027 rst asserted mid-frame SHALL discard the partial frame, and the next frame SHALL require frame_sync regardless of STRICT_SYNC.

Configuration
REQ-028 With macro TDM_DEMUX_PARITY_EN defined, the frame SHALL be 9 slots, slot 8 SHALL be an even-parity bit over slots 0-7, and sel SHALL show 3'd0 during the parity slot.
REQ-029 With TDM_DEMUX_PARITY_EN defined, parity_err SHALL be registered alongside dout and dout_valid on frame end (1 = mismatch) and held with that dout; the frame SHALL still be delivered.
REQ-030 Without TDM_DEMUX_PARITY_EN, the frame SHALL be 8 slots and parity_err SHALL be tied to 0.

Structure
REQ-031 Package tdm_pkg SHALL hold the FSM state enum, TDM_SLOTS=8 and the slot index width, shared with a future tdm_mux_8to1 transmitter.
REQ-032 The block SHALL contain one sub-module, tdm_slot_counter: a wrapping slot counter with clear, enable and terminal-count flag, sized by the macro.

Verification
REQ-033 The bench SHALL drive rst 2 cycles, then sync + sin 0,1,0,1,0,1,0,1 on consecutive cycles with dout_ready=1, and require dout=8'b10101010 with a dout_valid pulse 1 cycle after the last bit.
REQ-034 The bench SHALL drive a frame with sin_valid low for 3 cycles between slots 3 and 4, and require the same dout with completion delayed by 3 cycles.
REQ-035 The bench SHALL drive a sync at slot 5, then a full frame 8'hC3, and require sync_err=1 and dout=8'hC3 (partial frame dropped).
REQ-036 The bench SHALL send two frames 8'h55 then 8'hAA with dout_ready=0, and require dout=8'hAA and overrun=1; it SHALL then set dout_ready=1 and require dout_valid to clear.
REQ-037 The bench SHALL drive rst for 1 cycle after slot 4, then 4 more bits with no sync, and require dout_valid to stay 0.
REQ-038 With TDM_DEMUX_PARITY_EN defined, the bench SHALL send 8'h07 with parity bit 0 and require parity_err=1 with dout=8'h07; with parity bit 1 it SHALL require parity_err=0.
